// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA draw arbiter and the game-side requesters.
package vga_draw_pkg;

  localparam int DEF_X_W    = 8;
  localparam int DEF_Y_W    = 7;
  localparam int DEF_COL_W  = 3;
  localparam int DEF_SIZE_W = 4;

  // Visible area the requesters draw into; the arbiter itself never clips.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LATCH = ST_LATCH,
    DRAW  = ST_DRAW,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the VGA frame-buffer write port; rasterises one
// filled rectangle per grant at one pixel per clock and pulses done when finished.
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*X_W-1:0]    rect_x,
  input  logic [N_REQ*Y_W-1:0]    rect_y,
  input  logic [N_REQ*SIZE_W-1:0] rect_w,
  input  logic [N_REQ*SIZE_W-1:0] rect_h,
  input  logic [N_REQ*COL_W-1:0]  rect_col,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COL_W-1:0]        vga_colour,
  output logic                    vga_plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    winIdx_q, winIdx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [SIZE_W-1:0]   w_q, w_d;
  logic [SIZE_W-1:0]   h_q, h_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [SIZE_W-1:0]   cx_q, cx_d;
  logic [SIZE_W-1:0]   cy_q, cy_d;

  logic                pickFound;
  logic [IDX_W-1:0]    pickIdx;
  logic [X_W-1:0]      selX;
  logic [Y_W-1:0]      selY;
  logic [SIZE_W-1:0]   selW;
  logic [SIZE_W-1:0]   selH;
  logic [COL_W-1:0]    selCol;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .found_o(pickFound),
    .idx_o  (pickIdx)
  );

  // Geometry of the registered winner; only sampled while in LATCH.
  assign selX   = rect_x[winIdx_q*X_W +: X_W];
  assign selY   = rect_y[winIdx_q*Y_W +: Y_W];
  assign selW   = rect_w[winIdx_q*SIZE_W +: SIZE_W];
  assign selH   = rect_h[winIdx_q*SIZE_W +: SIZE_W];
  assign selCol = rect_col[winIdx_q*COL_W +: COL_W];

  always_comb begin
    state_d  = state_q;
    winIdx_d = winIdx_q;
    ptr_d    = ptr_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          winIdx_d = pickIdx;
          state_d  = LATCH;
        end
      end
      LATCH: begin
        x0_d  = selX;
        y0_d  = selY;
        w_d   = selW;
        h_d   = selH;
        col_d = selCol;
        cx_d  = '0;
        cy_d  = '0;
        state_d = (selW == '0 || selH == '0) ? DONE : DRAW;
      end
      DRAW: begin
        if (cx_q == w_q - SIZE_W'(1)) begin
          cx_d = '0;
          if (cy_q == h_q - SIZE_W'(1)) begin
            state_d = DONE;
          end else begin
            cy_d = cy_q + SIZE_W'(1);
          end
        end else begin
          cx_d = cx_q + SIZE_W'(1);
        end
      end
      DONE: begin
        ptr_d   = (winIdx_q == IDX_W'(N_REQ - 1)) ? '0 : winIdx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel outputs are forced to zero outside DRAW so waveforms compare cleanly.
  always_comb begin
    grant      = '0;
    done       = '0;
    busy       = (state_q != IDLE);
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (state_q != IDLE) begin
      grant = N_REQ'(1) << winIdx_q;
    end
    if (state_q == DONE) begin
      done = N_REQ'(1) << winIdx_q;
    end
    if (state_q == DRAW) begin
      vga_plot   = 1'b1;
      vga_x      = x0_q + X_W'(cx_q);
      vga_y      = y0_q + Y_W'(cy_q);
      vga_colour = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      winIdx_q <= '0;
      ptr_q    <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      state_q  <= state_d;
      winIdx_q <= winIdx_d;
      ptr_q    <= ptr_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: a transaction-level expected-output
// queue compared every cycle, plus directed scenarios with literal expectations.
module tb_vga_draw_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] rectX;
  logic [27:0] rectY;
  logic [15:0] rectW;
  logic [15:0] rectH;
  logic [11:0] rectCol;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        vgaPlot;

  int checkCount = 0;
  int passCount  = 0;

  vga_draw_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rect_x    (rectX),
    .rect_y    (rectY),
    .rect_w    (rectW),
    .rect_h    (rectH),
    .rect_col  (rectCol),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .vga_x     (vgaX),
    .vga_y     (vgaY),
    .vga_colour(vgaColour),
    .vga_plot  (vgaPlot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle's worth of expected outputs.
  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } rec_t;

  rec_t cur;
  rec_t expQ[$];
  bit   modelValid = 0;
  bit   pending    = 0;
  int   mPtr       = 0;
  int   mWin       = 0;

  // Model: on a grant, the whole transaction (latch, w*h pixels, done) is
  // queued as per-cycle records; after any transaction one idle cycle follows.
  always @(posedge clk) begin
    if (reset) begin
      cur        = '0;
      expQ.delete();
      pending    = 0;
      mPtr       = 0;
      modelValid = 1;
    end else if (modelValid) begin
      if (pending) begin
        int w, h, x0, y0, col;
        rec_t r;
        pending = 0;
        x0  = int'(rectX[mWin*8 +: 8]);
        y0  = int'(rectY[mWin*7 +: 7]);
        w   = int'(rectW[mWin*4 +: 4]);
        h   = int'(rectH[mWin*4 +: 4]);
        col = int'(rectCol[mWin*3 +: 3]);
        for (int row = 0; row < h; row++) begin
          for (int c = 0; c < w; c++) begin
            r       = '0;
            r.grant = 4'(1 << mWin);
            r.busy  = 1'b1;
            r.plot  = 1'b1;
            r.x     = 8'((x0 + c) % 256);
            r.y     = 7'((y0 + row) % 128);
            r.col   = 3'(col);
            expQ.push_back(r);
          end
        end
        r       = '0;
        r.grant = 4'(1 << mWin);
        r.done  = 4'(1 << mWin);
        r.busy  = 1'b1;
        expQ.push_back(r);
      end
      if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        if (cur.done != 0) mPtr = (mWin + 1) % 4;
      end else if (cur.busy) begin
        cur = '0;
      end else if (req != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(mPtr + k) % 4]) begin
            mWin = (mPtr + k) % 4;
            break;
          end
        end
        cur       = '0;
        cur.grant = 4'(1 << mWin);
        cur.busy  = 1'b1;
        pending   = 1;
      end else begin
        cur = '0;
      end
    end
  end

  always @(negedge clk) begin
    rec_t act;
    if (modelValid) begin
      act = {grant, done, busy, vgaPlot, vgaX, vgaY, vgaColour};
      checkCount++;
      if (act === cur) passCount++;
      else $display("[TB] FAIL cycle_compare t=%0t actual=%h required=%h", $time, act, cur);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic setRect(input int i, input int x, input int y, input int w, input int h, input int col);
    rectX[i*8 +: 8]   = 8'(x);
    rectY[i*7 +: 7]   = 7'(y);
    rectW[i*4 +: 4]   = 4'(w);
    rectH[i*4 +: 4]   = 4'(h);
    rectCol[i*3 +: 3] = 3'(col);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitDone(output int idx);
    idx = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done != 0) begin
        for (int b = 0; b < 4; b++) if (done[b]) idx = b;
        return;
      end
    end
    $display("[TB] FAIL waitDone_timeout actual=none required=done pulse");
    checkCount++;
  endtask

  initial begin
    int ex[4];
    int ey[4];
    int order[5];
    int wx[8];
    int d, plots, lastX, lastY, cyc;

    reset   = 1'b1;
    req     = '0;
    rectX   = '0;
    rectY   = '0;
    rectW   = '0;
    rectH   = '0;
    rectCol = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_grant", int'(grant), 0);
    checkOutput("reset_plot", int'(vgaPlot), 0);

    // 2x2 at (10,20), colour 3
    $display("[TB] single 2x2 rectangle");
    ex = '{10, 11, 10, 11};
    ey = '{20, 20, 21, 21};
    setRect(0, 10, 20, 2, 2, 3);
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("t1_grant", int'(grant), 1);
    checkOutput("t1_latch_plot", int'(vgaPlot), 0);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      checkOutput("t1_plot", int'(vgaPlot), 1);
      checkOutput("t1_x", int'(vgaX), ex[p]);
      checkOutput("t1_y", int'(vgaY), ey[p]);
      checkOutput("t1_col", int'(vgaColour), 3);
    end
    @(negedge clk);
    checkOutput("t1_done", int'(done), 1);
    checkOutput("t1_done_plot", int'(vgaPlot), 0);
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("t1_idle_busy", int'(busy), 0);

    // Simultaneous req0 and req2 from reset
    $display("[TB] simultaneous requests");
    doReset();
    for (int i = 0; i < 4; i++) setRect(i, 40 + i, 50 + i, 1, 1, i + 1);
    applyStimulus(4'b0101);
    waitDone(d);
    checkOutput("rr_first", d, 0);
    applyStimulus(4'b0100);
    waitDone(d);
    checkOutput("rr_second", d, 2);
    applyStimulus(4'b0000);
    @(negedge clk);

    // All four held continuously from reset
    $display("[TB] all four requesters held");
    doReset();
    order = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      waitDone(d);
      checkOutput("rr_order", d, order[k]);
      if (k == 4) applyStimulus(4'b0000);
      @(negedge clk);
      checkOutput("rr_done_single", int'(done), 0);
    end
    @(negedge clk);

    // Zero width, requester 1
    $display("[TB] zero-size rectangle");
    setRect(1, 30, 40, 0, 5, 2);
    applyStimulus(4'b0010);
    @(negedge clk);
    checkOutput("zero_grant", int'(grant), 2);
    @(negedge clk);
    checkOutput("zero_done", int'(done), 2);
    checkOutput("zero_plot", int'(vgaPlot), 0);
    applyStimulus(4'b0000);
    @(negedge clk);

    // Coordinate wrap, requester 2
    $display("[TB] coordinate wrap");
    wx = '{254, 255, 0, 1, 254, 255, 0, 1};
    setRect(2, 254, 119, 4, 2, 5);
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("wrap_grant", int'(grant), 4);
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      checkOutput("wrap_plot", int'(vgaPlot), 1);
      checkOutput("wrap_x", int'(vgaX), wx[p]);
      checkOutput("wrap_y", int'(vgaY), (p < 4) ? 119 : 120);
    end
    @(negedge clk);
    checkOutput("wrap_done", int'(done), 4);
    applyStimulus(4'b0000);
    @(negedge clk);

    // Maximum 15x15, requester 3
    $display("[TB] maximum size rectangle");
    setRect(3, 20, 30, 15, 15, 6);
    applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("max_grant", int'(grant), 8);
    plots = 0;
    lastX = -1;
    lastY = -1;
    cyc   = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      cyc++;
      if (done != 0) break;
      if (vgaPlot) begin
        plots++;
        lastX = int'(vgaX);
        lastY = int'(vgaY);
      end
    end
    checkOutput("max_plots", plots, 225);
    checkOutput("max_last_x", lastX, 34);
    checkOutput("max_last_y", lastY, 44);
    checkOutput("max_done", int'(done), 8);
    checkOutput("max_done_latency", cyc, 226);
    applyStimulus(4'b0000);
    @(negedge clk);

    // Reset during the third pixel of a 4x4
    $display("[TB] reset mid-draw");
    setRect(0, 50, 60, 4, 4, 1);
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("rst_grant", int'(grant), 1);
    repeat (3) @(negedge clk);
    checkOutput("rst_pixel3_x", int'(vgaX), 52);
    reset = 1'b1;
    applyStimulus(4'b0000);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_plot", int'(vgaPlot), 0);
    checkOutput("rst_grant_clear", int'(grant), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    setRect(3, 5, 5, 1, 1, 7);
    applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("rst_regrant", int'(grant), 8);
    waitDone(d);
    checkOutput("rst_regrant_done", d, 3);
    applyStimulus(4'b0000);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single frame-buffer write port (vga_x/vga_y/vga_colour/vga_plot into the VGA adapter) between N_REQ drawing requesters, for example player, obstacle, score and clear.
- Each requester asks for one filled rectangle; the block grants one requester at a time in round-robin order.
- The granted rectangle is rasterised one pixel per clock, and completion is signalled back to the requester with a one-cycle done pulse.
- Sits between the per-object game control FSMs and the VGA adapter, replacing direct writeEn muxing.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COL_W, 3, colour width
- SIZE_W, 4, rectangle width/height field width (max 2^SIZE_W-1 pixels per side)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state on the next clk edge
- req  in  N_REQ  per-requester draw request; level, held until done
- rect_x  in  N_REQ*X_W  packed origin x; requester i at bits [i*X_W +: X_W]
- rect_y  in  N_REQ*Y_W  packed origin y
- rect_w  in  N_REQ*SIZE_W  packed width in pixels
- rect_h  in  N_REQ*SIZE_W  packed height in pixels
- rect_col  in  N_REQ*COL_W  packed fill colour
- grant  out  N_REQ  one-hot; the requester being served (LATCH through DONE)
- done  out  N_REQ  one-cycle pulse to the served requester when its rectangle is complete
- busy  out  1  high in any state other than IDLE
- vga_x  out  X_W  pixel x to the adapter
- vga_y  out  Y_W  pixel y to the adapter
- vga_colour  out  COL_W  pixel colour
- vga_plot  out  1  write enable, high exactly once per drawn pixel

Behaviour:
- States: IDLE, LATCH, DRAW, DONE.
- IDLE → LATCH when |req. The winner is the first set req bit searching upward (with wrap) from the priority pointer ptr. The winner index is registered.
- LATCH (1 cycle): geometry of the winner is captured into internal x0, y0, w, h, col. Counters cx = cy = 0. grant is one-hot on the winner from this cycle through DONE inclusive.
  - If w==0 or h==0: go to DONE (no pixels).
  - Otherwise: go to DRAW.
- DRAW:
  - Outputs: vga_plot=1, vga_x=(x0+cx) mod 2^X_W, vga_y=(y0+cy) mod 2^Y_W, vga_colour=col. These are combinational from the registered counters and state.
  - Order is row-major: cx increments each cycle. When cx==w-1, cx resets to 0 and cy increments.
  - When cx==w-1 and cy==h-1, go to DONE.
  - Exactly w*h DRAW cycles.
- DONE (1 cycle): done[winner]=1, ptr ← (winner+1) mod N_REQ, then go to IDLE.
- Latency:
  - req rising in IDLE at cycle t gives grant at t+1 and first pixel at t+2.
  - done occurs at t+2+w*h.
  - Minimum one IDLE cycle between consecutive grants.
- Input changes:
  - Geometry changes after LATCH are ignored.
  - Deasserting req mid-draw does not abort; the rectangle completes and done still pulses.
  - Requesters must drop req in the cycle after done, or they are re-arbitrated (still subject to round-robin).
- Simultaneous requests: resolved only by ptr; no fixed priority. ptr resets to 0.
- Outputs when not in DRAW: vga_plot=0. vga_x, vga_y, vga_colour are driven 0 outside DRAW (deterministic for waveform compare).
- Reset values: state IDLE, ptr 0, grant 0, done 0, busy 0, vga_plot 0, vga_x/y/colour 0, all counters 0.
- Reset mid-operation: takes effect on the next edge regardless of state. The interrupted rectangle is abandoned with no done pulse.
- Coordinate arithmetic is X_W/Y_W bits with silent wrap; no clipping.

Decomposition:
- Package vga_draw_pkg holds:
  - state encoding localparams (IDLE=0, LATCH=1, DRAW=2, DONE=3)
  - default widths X_W/Y_W/COL_W/SIZE_W
  - the screen constants (160x120) used by requesters
- Sub-module rr_pick: combinational round-robin selector. Inputs req[N_REQ] and ptr; outputs found and idx. Instantiated once.

Test Plan:
- Single 2x2 from req0 at (10,20), col 3, after reset → grant=0001 at t+1; pixels (10,20),(11,20),(10,21),(11,21) at t+2..t+5 with colour 3; done[0] at t+6; vga_plot high exactly 4 cycles.
- req0 and req2 high together from reset, each 1x1 → req0 served first, then req2. With all four held continuously, grant order is 0,1,2,3,0 and each done is a single cycle.
- Zero size: req1 with w=0,h=5 → grant at t+1, done[1] at t+2, vga_plot never high.
- Wrap: x=254, y=119, w=4, h=2 → x sequence 254,255,0,1 on rows y=119 then y=120 (7-bit, no clip); 8 plot cycles.
- Max size 15x15 → exactly 225 consecutive plot cycles, last pixel (x0+14,y0+14), done at t+227.
- Reset asserted during DRAW pixel 3 of a 4x4 → next cycle vga_plot=0, grant=0, busy=0, no done. A later req3 is granted with ptr restarted at 0.
